dijkstra_path_extractor: RTL and testbench
==========================================

Name: dijkstra_path_extractor

Overview:
- Downstream consumer of DijkstraTop. Once the solver asserts ready, this block walks the previous-node array that DijkstraTop left in BlockRam, from destination back to source.
- It stacks the visited nodes internally, then streams the path out in source-to-destination order over a valid/accept handshake.
- It shares the BlockRam read port with DijkstraTop and the loader. It drives the bus only while it is walking.

Parameters:
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH: memory address width.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH: memory data width.
- MAX_NODES, `DEFAULT_MAX_NODES: maximum graph size; also the stack depth.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH: node index width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  start request; the block acts on it only while in IDLE.
- source  input  INDEX_WIDTH  path start node.
- destination  input  INDEX_WIDTH  path end node.
- number_of_nodes  input  INDEX_WIDTH  graph size N.
- base_address  input  MADDR_WIDTH  graph base address in BlockRam.
- mem_read_enable  output(tri)  1  read request; 'z when the bus is not owned.
- mem_addr  output(tri)  MADDR_WIDTH  read address; 'z when the bus is not owned.
- mem_read_ready  input  1  BlockRam read data valid.
- mem_read_data  input  MDATA_WIDTH  read data; the low INDEX_WIDTH bits are used.
- path_node  output  INDEX_WIDTH  current path element.
- path_valid  output  1  path_node is valid.
- path_accept  input  1  consumer takes path_node.
- path_length  output  INDEX_WIDTH  node count, including source and destination; valid from EMIT onward.
- done  output  1  high in DONE; held until enable drops.
- error  output  1  high in ERROR; held until enable drops.

Behaviour:
- Reset (async, any state):
  - state=IDLE, stack pointer=0.
  - path_valid=0, done=0, error=0, path_length=0, path_node=0.
  - mem_read_enable='z, mem_addr='z. Reset mid-walk releases the bus immediately.
- IDLE:
  - On enable=1, latch source, destination, number_of_nodes and base_address. Set cur=destination.
  - Then branch, in this order:
    - destination>=N or source>=N: go to ERROR.
    - destination==source: push cur, go to EMIT. No memory read is made.
    - Otherwise: push cur, go to READ.
- READ:
  - Drive mem_read_enable=1.
  - Drive mem_addr = base_address + (N*N + cur)*(MADDR_WIDTH/8), computed modulo 2^MADDR_WIDTH.
  - Hold both until a cycle with mem_read_ready=1. Capture p = mem_read_data[INDEX_WIDTH-1:0] in that cycle.
  - Release both to 'z on the next cycle and go to CHECK. There is no timeout.
- CHECK (one cycle). Evaluate in this order:
  - p==`NO_PREVIOUS_NODE or p>=N: go to ERROR (unreachable or corrupt).
  - Stack holds N entries: go to ERROR (cycle detected).
  - Otherwise push p and set cur=p.
    - If p==source, set path_length = stack count and go to EMIT.
    - Otherwise go to READ.
- EMIT:
  - Pop the top of stack (the source first) onto path_node with path_valid=1.
  - path_node is held stable while path_accept=0.
  - When path_valid & path_accept: pop the next entry in the next cycle. With no bubbles, one node transfers per clock.
  - After the last node (the destination) is accepted, path_valid=0 and go to DONE.
- DONE / ERROR:
  - Outputs held; the bus stays 'z; path_valid=0.
  - Return to IDLE when enable=0. enable held high never causes a restart.
- enable dropping outside IDLE/DONE/ERROR is ignored: the walk completes.
- Bus ownership: mem_read_enable and mem_addr are 'z in every state except READ. mem_write_* ports are never driven.
- Maximum reads per run: N-1.

Decomposition:
- Shared constants header / package (the existing constants.v):
  - `NO_PREVIOUS_NODE and the `DEFAULT_* widths.
  - New: the state enum, and a PREV_ARRAY_OFFSET(N) helper returning N*N.
- One sub-module: path_stack, a MAX_NODES x INDEX_WIDTH LIFO.
  - Ports: push, pop, data_in, top, count, full, empty.
  - Synchronous push/pop. Simultaneous push and pop is illegal and never issued by the FSM.

Test Plan:
- Chain walk: N=8, source=0, destination=7; prev[7]=5, prev[5]=3, prev[3]=0.
  -> Exactly 3 reads at base+(64+7)*(MADDR_WIDTH/8), then +5, then +3.
  -> Stream 0,3,5,7; path_length=4; done=1; error=0.
- source==destination=4, N=8 -> no mem_read_enable pulse; stream 4; path_length=1; done=1.
- Unreachable: N=8, destination=6, prev[6]=`NO_PREVIOUS_NODE -> one read, then error=1; path_valid never rises.
- Cycle: N=4, source=0, destination=3; prev[3]=2, prev[2]=1, prev[1]=3 -> error=1 after at most 3 reads.
- Backpressure: chain case with path_accept=0 for 5 cycles on each node -> path_node stable while stalled; order still 0,3,5,7; no node lost or duplicated.
- Reset mid-walk: assert reset while mem_read_enable=1 -> mem_read_enable/mem_addr are 'z in the same cycle; all outputs 0. A new enable then yields the correct path.

Source files
------------

// File: rtl/dijkstra_path_extractor_pkg.sv
// rtl/dijkstra_path_extractor_pkg.sv - shared widths, sentinel and state encoding for the path extractor
package dijkstra_path_extractor_pkg;
    localparam int DEFAULT_MADDR_WIDTH = 16;
    localparam int DEFAULT_MDATA_WIDTH = 16;
    localparam int DEFAULT_MAX_NODES   = 16;
    localparam int DEFAULT_INDEX_WIDTH = 8;
    localparam int NO_PREVIOUS_NODE    = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_EMIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    // The previous-node array is stored right after the N x N adjacency matrix.
    function automatic logic [31:0] prev_array_offset(input logic [31:0] n);
        return n * n;
    endfunction
endpackage

// File: rtl/dijkstra_path_extractor_path_stack.sv
// rtl/dijkstra_path_extractor_path_stack.sv - LIFO holding the walked nodes, destination at the bottom
module path_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[AW'(count - CW'(1))];

    // clear together with push restarts the stack with a single entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= push ? CW'(1) : '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && (clear || !full)) begin
            mem[clear ? AW'(0) : AW'(count)] <= data_in;
        end
    end
endmodule

// File: rtl/dijkstra_path_extractor.sv
// rtl/dijkstra_path_extractor.sv - walks the previous-node array back from destination and streams the path
module dijkstra_path_extractor
    import dijkstra_path_extractor_pkg::*;
#(
    parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
    parameter int MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INDEX_WIDTH-1:0] source,
    input  logic [INDEX_WIDTH-1:0] destination,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [MADDR_WIDTH-1:0] base_address,
    output tri logic               mem_read_enable,
    output tri logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_read_ready,
    input  logic [MDATA_WIDTH-1:0] mem_read_data,
    output logic [INDEX_WIDTH-1:0] path_node,
    output logic                   path_valid,
    input  logic                   path_accept,
    output logic [INDEX_WIDTH-1:0] path_length,
    output logic                   done,
    output logic                   error
);
    localparam int CW = $clog2(MAX_NODES + 1);
    localparam logic [INDEX_WIDTH-1:0] NO_PREV    = INDEX_WIDTH'(NO_PREVIOUS_NODE);
    localparam logic [MADDR_WIDTH-1:0] WORD_BYTES = MADDR_WIDTH'(MADDR_WIDTH / 8);

    state_t state, state_next;

    logic [INDEX_WIDTH-1:0] src_q, n_q, cur_q, prev_q;
    logic [MADDR_WIDTH-1:0] base_q, read_addr;
    logic                   stk_clear, stk_push, stk_pop, stk_full, stk_empty;
    logic [INDEX_WIDTH-1:0] stk_data, stk_top;
    logic [CW-1:0]          stk_count;
    logic                   prev_bad, prev_is_src, walk_full, emit_load, emit_last;
    logic                   unused_data_bits;

    assign unused_data_bits = ^mem_read_data;

    path_stack #(
        .DEPTH (MAX_NODES),
        .WIDTH (INDEX_WIDTH)
    ) u_stack (
        .clock   (clock),
        .reset   (reset),
        .clear   (stk_clear),
        .push    (stk_push),
        .pop     (stk_pop),
        .data_in (stk_data),
        .top     (stk_top),
        .count   (stk_count),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    assign read_addr = base_q
                     + (MADDR_WIDTH'(prev_array_offset(32'(n_q))) + MADDR_WIDTH'(cur_q)) * WORD_BYTES;

    assign mem_read_enable = (state == ST_READ) ? 1'b1 : 1'bz;
    assign mem_addr        = (state == ST_READ) ? read_addr : 'z;

    assign done  = (state == ST_DONE);
    assign error = (state == ST_ERROR);

    assign prev_bad    = (prev_q == NO_PREV) || (prev_q >= n_q);
    assign prev_is_src = (prev_q == src_q);
    // A walk that has not met the source within N nodes must be revisiting one.
    assign walk_full   = stk_full || (int'(stk_count) >= int'(n_q))
                       || (!prev_is_src && (int'(stk_count) + 1 >= int'(n_q)));

    assign emit_load = (state == ST_EMIT) && (!path_valid || path_accept) && !stk_empty;
    assign emit_last = (state == ST_EMIT) && path_valid && path_accept && stk_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_data   = destination;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    if (destination >= number_of_nodes || source >= number_of_nodes) begin
                        state_next = ST_ERROR;
                    end else begin
                        stk_clear  = 1'b1;
                        stk_push   = 1'b1;
                        state_next = (destination == source) ? ST_EMIT : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (mem_read_ready) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (prev_bad || walk_full) begin
                    state_next = ST_ERROR;
                end else begin
                    stk_push   = 1'b1;
                    stk_data   = prev_q;
                    state_next = prev_is_src ? ST_EMIT : ST_READ;
                end
            end
            ST_EMIT: begin
                stk_pop = emit_load;
                if (emit_last) state_next = ST_DONE;
            end
            ST_DONE, ST_ERROR: begin
                if (!enable) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q       <= '0;
            n_q         <= '0;
            cur_q       <= '0;
            prev_q      <= '0;
            base_q      <= '0;
            path_node   <= '0;
            path_valid  <= 1'b0;
            path_length <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        src_q       <= source;
                        n_q         <= number_of_nodes;
                        base_q      <= base_address;
                        cur_q       <= destination;
                        path_length <= (state_next == ST_EMIT) ? INDEX_WIDTH'(1) : '0;
                    end
                end
                ST_READ: begin
                    if (mem_read_ready) prev_q <= mem_read_data[INDEX_WIDTH-1:0];
                end
                ST_CHECK: begin
                    if (!prev_bad && !walk_full) begin
                        cur_q <= prev_q;
                        if (prev_is_src) path_length <= INDEX_WIDTH'(stk_count) + INDEX_WIDTH'(1);
                    end
                end
                ST_EMIT: begin
                    if (emit_load) begin
                        path_node  <= stk_top;
                        path_valid <= 1'b1;
                    end else if (emit_last) begin
                        path_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dijkstra_path_extractor.sv
// tb/tb_dijkstra_path_extractor.sv - randomized and directed bench for dijkstra_path_extractor
module tb_dijkstra_path_extractor;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXN = 16;
    localparam int IW   = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [IW-1:0] source = '0, destination = '0, number_of_nodes = '0;
    logic [AW-1:0] base_address = '0;
    wire           mem_read_enable;
    wire  [AW-1:0] mem_addr;
    logic          mem_read_ready = 1'b0;
    logic [DW-1:0] mem_read_data = '0;
    logic [IW-1:0] path_node;
    logic          path_valid;
    logic          path_accept = 1'b0;
    logic [IW-1:0] path_length;
    logic          done, error;

    dijkstra_path_extractor #(
        .MADDR_WIDTH (AW),
        .MDATA_WIDTH (DW),
        .MAX_NODES   (MAXN),
        .INDEX_WIDTH (IW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .source          (source),
        .destination     (destination),
        .number_of_nodes (number_of_nodes),
        .base_address    (base_address),
        .mem_read_enable (mem_read_enable),
        .mem_addr        (mem_addr),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .path_node       (path_node),
        .path_valid      (path_valid),
        .path_accept     (path_accept),
        .path_length     (path_length),
        .done            (done),
        .error           (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [int];
    logic [AW-1:0] got_reads [$];
    int            lat_max  = 2;
    int            wait_cnt = 0;
    int            cur_lat  = 0;
    bit            hold_bus = 1'b0;

    int            prev_arr [MAXN];
    int            exp_path [$];
    logic [AW-1:0] exp_reads [$];
    bit            exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // BlockRam stand-in: answers reads after a random latency
    always @(negedge clock) begin
        mem_read_ready = 1'b0;
        if (mem_read_enable === 1'b1 && !hold_bus) begin
            if (wait_cnt >= cur_lat) begin
                mem_read_ready = 1'b1;
                mem_read_data  = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : 16'hA5FF;
                got_reads.push_back(mem_addr);
                wait_cnt = 0;
                cur_lat  = $urandom_range(0, lat_max);
            end else begin
                wait_cnt++;
            end
        end
    end

    function automatic logic [AW-1:0] addr_of(input int base, input int n, input int i);
        return AW'(base + (n * n + i) * (AW / 8));
    endfunction

    // Reference: follow prev[] from destination, at most N-1 reads, then reverse.
    task automatic build_model(input int n, input int src, input int dst, input int base);
        int trail [$];
        int cur, p;
        exp_path.delete();
        exp_reads.delete();
        exp_err = 1'b0;
        if (dst >= n || src >= n) begin
            exp_err = 1'b1;
            return;
        end
        trail.push_back(dst);
        cur = dst;
        if (src != dst) begin
            exp_err = 1'b1;
            for (int r = 1; r <= n - 1; r++) begin
                exp_reads.push_back(addr_of(base, n, cur));
                p = prev_arr[cur];
                if (p == 255 || p >= n) break;
                trail.push_back(p);
                if (p == src) begin
                    exp_err = 1'b0;
                    break;
                end
                cur = p;
            end
        end
        if (!exp_err) begin
            for (int i = trail.size() - 1; i >= 0; i--) exp_path.push_back(trail[i]);
        end
    endtask

    function automatic int stall_len(input int stall);
        return (stall >= 0) ? stall : int'($urandom_range(0, 3));
    endfunction

    task automatic load_ram(input int n, input int base);
        ram.delete();
        for (int i = 0; i < n; i++) ram[int'(addr_of(base, n, i))] = {8'($urandom), 8'(prev_arr[i])};
        got_reads.delete();
    endtask

    task automatic run_case(input string name, input int n, input int src, input int dst,
                            input int base, input int stall);
        int            idx = 0;
        int            cyc = 0;
        int            stall_left;
        int            nreads;
        bit            saw_valid = 1'b0;
        bit            was_stalled = 1'b0;
        logic [IW-1:0] held = '0;
        build_model(n, src, dst, base);
        load_ram(n, base);
        @(negedge clock);
        number_of_nodes = IW'(n);
        source          = IW'(src);
        destination     = IW'(dst);
        base_address    = AW'(base);
        enable          = 1'b1;
        stall_left      = stall_len(stall);
        do begin
            @(negedge clock);
            cyc++;
            if (was_stalled) check({name, " stall_hold"}, {path_valid, path_node}, {1'b1, held});
            if (path_valid) begin
                saw_valid = 1'b1;
                if (stall_left > 0) begin
                    stall_left--;
                    path_accept = 1'b0;
                    was_stalled = 1'b1;
                    held = path_node;
                end else begin
                    if (idx < exp_path.size()) begin
                        check($sformatf("%s node%0d", name, idx), path_node, exp_path[idx]);
                    end else begin
                        check($sformatf("%s extra_node%0d", name, idx), 1, 0);
                    end
                    idx++;
                    path_accept = 1'b1;
                    was_stalled = 1'b0;
                    stall_left  = stall_len(stall);
                end
            end else begin
                path_accept = 1'($urandom_range(0, 1));
                was_stalled = 1'b0;
            end
        end while (!(done || error) && cyc < 3000);
        path_accept = 1'b0;
        check({name, " timeout"}, cyc >= 3000, 0);
        check({name, " done"}, done, !exp_err);
        check({name, " error"}, error, exp_err);
        check({name, " node_count"}, idx, exp_path.size());
        if (!exp_err) check({name, " path_length"}, path_length, exp_path.size());
        else check({name, " valid_in_error"}, saw_valid, 0);
        nreads = got_reads.size();
        check({name, " read_count"}, nreads, exp_reads.size());
        for (int i = 0; i < exp_reads.size() && i < nreads; i++)
            check($sformatf("%s read_addr%0d", name, i), got_reads[i], exp_reads[i]);
        repeat (3) @(negedge clock);
        check({name, " hold_status"}, {done, error, path_valid}, {!exp_err, exp_err, 1'b0});
        check({name, " no_restart"}, got_reads.size(), nreads);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        check({name, " released"}, {done, error, mem_read_enable === 1'b1}, 3'b000);
    endtask

    task automatic set_chain();
        for (int i = 0; i < MAXN; i++) prev_arr[i] = 255;
        prev_arr[7] = 5;
        prev_arr[5] = 3;
        prev_arr[3] = 0;
    endtask

    task automatic random_case(input int k);
        int n, src, dst, r, cur, kk, v, j, t;
        int perm [MAXN];
        n   = $urandom_range(1, MAXN);
        src = $urandom_range(0, n - 1);
        dst = $urandom_range(0, n - 1);
        if ($urandom_range(0, 11) == 0) dst = n + $urandom_range(0, 3);
        if ($urandom_range(0, 11) == 0) src = n + $urandom_range(0, 3);
        for (int i = 0; i < MAXN; i++) begin
            r = $urandom_range(0, 9);
            prev_arr[i] = (r == 0) ? 255 : (r == 1) ? n + 3 : int'($urandom_range(0, n - 1));
        end
        if ($urandom_range(0, 2) != 0 && src < n && dst < n && src != dst) begin
            for (int i = 0; i < n; i++) perm[i] = i;
            for (int i = n - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            cur = dst;
            kk  = $urandom_range(0, n - 2);
            for (int i = 0; i < n && kk > 0; i++) begin
                v = perm[i];
                if (v != src && v != dst) begin
                    prev_arr[cur] = v;
                    cur = v;
                    kk--;
                end
            end
            prev_arr[cur] = src;
        end
        lat_max = $urandom_range(0, 3);
        run_case($sformatf("rand%0d", k), n, src, dst, int'($urandom_range(0, 65535)), -1);
    endtask

    initial begin
        int waited;
        repeat (2) @(negedge clock);
        check("reset outputs", {path_valid, done, error}, 3'b000);
        check("reset path_length", path_length, 0);
        check("reset path_node", path_node, 0);
        check("reset bus", mem_read_enable === 1'b1, 0);
        reset = 1'b0;

        set_chain();
        build_model(8, 0, 7, 16'h0100);
        check("model chain read0", exp_reads[0], 16'h018E);
        check("model chain read2", exp_reads[2], 16'h0186);
        check("model chain len", exp_path.size(), 4);
        check("model chain path1", exp_path[1], 3);
        run_case("chain", 8, 0, 7, 16'h0100, 0);
        check("chain lit reads", got_reads.size(), 3);
        check("chain lit read0", got_reads[0], 16'h018E);
        check("chain lit read1", got_reads[1], 16'h018A);
        check("chain lit read2", got_reads[2], 16'h0186);
        check("chain lit path_length", path_length, 4);

        run_case("same", 8, 4, 4, 16'h0200, 0);
        check("same lit reads", got_reads.size(), 0);
        check("same lit path_length", path_length, 1);

        for (int i = 0; i < MAXN; i++) prev_arr[i] = 255;
        run_case("unreach", 8, 0, 6, 16'h0300, 0);
        check("unreach lit reads", got_reads.size(), 1);

        for (int i = 0; i < MAXN; i++) prev_arr[i] = 255;
        prev_arr[3] = 2;
        prev_arr[2] = 1;
        prev_arr[1] = 3;
        run_case("cycle", 4, 0, 3, 16'h0400, 0);
        check("cycle lit reads", got_reads.size(), 3);

        set_chain();
        run_case("backpressure", 8, 0, 7, 16'h0100, 5);

        set_chain();
        load_ram(8, 16'h0100);
        hold_bus = 1'b1;
        @(negedge clock);
        number_of_nodes = 8;
        source          = 0;
        destination     = 7;
        base_address    = 16'h0100;
        enable          = 1'b1;
        waited          = 0;
        while (mem_read_enable !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check("midreset bus owned", mem_read_enable === 1'b1, 1);
        #2 reset = 1'b1;
        #1;
        check("midreset bus released", mem_read_enable === 1'b1, 0);
        check("midreset outputs", {path_valid, done, error}, 3'b000);
        check("midreset length/node", {path_length, path_node}, 16'h0000);
        enable = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        hold_bus = 1'b0;
        run_case("after_reset", 8, 0, 7, 16'h0100, -1);

        for (int k = 0; k < 40; k++) random_case(k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
